// File: rtl/hazard_if.sv
// Decode-side hazard bus: ID instruction qualifiers and pipeline events in,
// forwarding selects and pipeline control out.
interface hazard_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_reg1_RE_i;
  logic              id_reg2_RE_i;
  logic              id_reg_we_i;
  logic              id_is_load_i;
  logic              ex_branch_taken_i;
  logic              mem_hold_i;
  logic [1:0]        hz_fwd1_sel_o;
  logic [1:0]        hz_fwd2_sel_o;
  logic              hz_stall_o;
  logic              hz_bubble_o;
  logic              hz_flush_o;
  logic              hz_freeze_o;
  logic [CNT_W-1:0]  hz_bubble_cnt_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_reg1_RE_i, id_reg2_RE_i,
           id_reg_we_i, id_is_load_i, ex_branch_taken_i, mem_hold_i,
    input  hz_fwd1_sel_o, hz_fwd2_sel_o, hz_stall_o, hz_bubble_o, hz_flush_o,
           hz_freeze_o, hz_bubble_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_reg1_RE_i, id_reg2_RE_i,
           id_reg_we_i, id_is_load_i, ex_branch_taken_i, mem_hold_i,
    output hz_fwd1_sel_o, hz_fwd2_sel_o, hz_stall_o, hz_bubble_o, hz_flush_o,
           hz_freeze_o, hz_bubble_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Data-hazard / forwarding unit for the 5-stage core: tracks EX/MEM/WB
// destinations and derives forwarding selects, load-use bubbles and flushes.
module hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  hz
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  logic              ex_v, ex_we, ex_ld;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_v, mem_we;
  logic [REG_AW-1:0] mem_rd;
  logic              wb_v, wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic [CNT_W-1:0]  bubble_cnt;

  logic m_ex1, m_mem1, m_wb1, m_ex2, m_mem2, m_wb2;
  logic load_use, flush_c, bubble_c;

  function automatic logic stage_match(input logic s_v, input logic s_we,
                                       input logic [REG_AW-1:0] s_rd,
                                       input logic re, input logic [REG_AW-1:0] rs);
    return hz.id_valid_i & re & (rs != '0) & s_v & s_we & (s_rd == rs);
  endfunction

  // Newest producer wins; a load still in EX cannot forward yet.
  function automatic logic [1:0] pick_sel(input logic me, input logic mm,
                                          input logic mw, input logic ld);
    if (me)      return ld ? SEL_RF : SEL_EX;
    else if (mm) return SEL_MEM;
    else if (mw) return SEL_WB;
    else         return SEL_RF;
  endfunction

  always_comb begin
    m_ex1  = stage_match(ex_v,  ex_we,  ex_rd,  hz.id_reg1_RE_i, hz.id_rs1_i);
    m_mem1 = stage_match(mem_v, mem_we, mem_rd, hz.id_reg1_RE_i, hz.id_rs1_i);
    m_wb1  = stage_match(wb_v,  wb_we,  wb_rd,  hz.id_reg1_RE_i, hz.id_rs1_i);
    m_ex2  = stage_match(ex_v,  ex_we,  ex_rd,  hz.id_reg2_RE_i, hz.id_rs2_i);
    m_mem2 = stage_match(mem_v, mem_we, mem_rd, hz.id_reg2_RE_i, hz.id_rs2_i);
    m_wb2  = stage_match(wb_v,  wb_we,  wb_rd,  hz.id_reg2_RE_i, hz.id_rs2_i);

    load_use = (m_ex1 | m_ex2) & ex_ld;
    flush_c  = hz.ex_branch_taken_i & ~hz.mem_hold_i;
    bubble_c = load_use & ~hz.ex_branch_taken_i & ~hz.mem_hold_i;

    hz.hz_fwd1_sel_o   = pick_sel(m_ex1, m_mem1, m_wb1, ex_ld);
    hz.hz_fwd2_sel_o   = pick_sel(m_ex2, m_mem2, m_wb2, ex_ld);
    hz.hz_freeze_o     = hz.mem_hold_i;
    hz.hz_flush_o      = flush_c;
    hz.hz_bubble_o     = bubble_c;
    hz.hz_stall_o      = hz.mem_hold_i | bubble_c;
    hz.hz_bubble_cnt_o = bubble_cnt;
  end

  // Shadow pipeline of destination info; frozen while memory holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v   <= 1'b0;
      ex_we  <= 1'b0;
      ex_ld  <= 1'b0;
      ex_rd  <= '0;
      mem_v  <= 1'b0;
      mem_we <= 1'b0;
      mem_rd <= '0;
      wb_v   <= 1'b0;
      wb_we  <= 1'b0;
      wb_rd  <= '0;
    end else if (!hz.mem_hold_i) begin
      wb_v   <= mem_v;
      wb_we  <= mem_we;
      wb_rd  <= mem_rd;
      mem_v  <= ex_v;
      mem_we <= ex_we;
      mem_rd <= ex_rd;
      if (flush_c || bubble_c) begin
        ex_v  <= 1'b0;
        ex_we <= 1'b0;
        ex_ld <= 1'b0;
        ex_rd <= '0;
      end else begin
        ex_v  <= hz.id_valid_i;
        ex_we <= hz.id_reg_we_i;
        ex_ld <= hz.id_is_load_i;
        ex_rd <= hz.id_rd_i;
      end
    end
  end

  // Saturating bubble counter; bubble_c already excludes hold cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (bubble_c && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Consumer end of the decode-side register-read qualifiers (reg1/reg2 read enables, reg write enable), the data-hazard/forwarding unit of the 5-stage core.
- Keeps its own shadow of destination info for the EX, MEM and WB stages.
- From that shadow and the current ID instruction it produces operand-forwarding selects, load-use stall/bubble, and branch flush.
- Also counts inserted load-use bubbles for performance monitoring.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, bubble counter width.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- id_valid_i  input  1  ID holds a real instruction.
- id_rs1_i  input  REG_AW  ID source register 1.
- id_rs2_i  input  REG_AW  ID source register 2.
- id_rd_i  input  REG_AW  ID destination register.
- id_reg1_RE_i  input  1  ID reads rs1.
- id_reg2_RE_i  input  1  ID reads rs2.
- id_reg_we_i  input  1  ID writes rd.
- id_is_load_i  input  1  ID instruction is a load.
- ex_branch_taken_i  input  1  EX resolved a taken branch/jump; redirect this cycle.
- mem_hold_i  input  1  data memory not ready; whole pipeline freezes.
- hz_fwd1_sel_o  output  2  rs1 source: 00 regfile, 01 EX result, 10 MEM result, 11 WB result.
- hz_fwd2_sel_o  output  2  rs2 source, same encoding.
- hz_stall_o  output  1  hold PC and IF/ID register.
- hz_bubble_o  output  1  load ID/EX register with NOP.
- hz_flush_o  output  1  clear IF/ID and ID/EX registers.
- hz_freeze_o  output  1  freeze all pipeline registers.
- hz_bubble_cnt_o  output  CNT_W  saturating count of load-use bubbles.

Behaviour:
- State: EX shadow {ex_v, ex_rd, ex_we, ex_ld}, MEM shadow {mem_v, mem_rd, mem_we}, WB shadow {wb_v, wb_rd, wb_we}, bubble counter.
- Reset: all state clears immediately, no clock needed. All *_v = 0, counter = 0.
- All outputs are combinational from current state plus inputs. With state cleared, outputs are fwd sel 00, stall/bubble/flush 0, freeze = mem_hold_i, count 0.
- Stage match, per stage S in {EX, MEM, WB} and source n:
  - match_S_n = id_valid_i & id_regn_RE_i & (id_rsn_i != 0) & S_v & S_we & (S_rd == id_rsn_i).
  - x0 never forwards and never stalls.
- Forward select priority is newest first: EX > MEM > WB > regfile.
  - If the selected stage is EX and ex_ld = 1, the select is 00 and a load-use hazard is raised instead.
- load_use = (match_EX_1 | match_EX_2) & ex_ld.
- Output equations:
  - hz_freeze_o = mem_hold_i.
  - hz_flush_o = ex_branch_taken_i & ~mem_hold_i.
  - hz_bubble_o = load_use & ~ex_branch_taken_i & ~mem_hold_i.
  - hz_stall_o = mem_hold_i | hz_bubble_o.
- Priority: hold > flush > load-use. A flush discards the ID instruction, so its load-use hazard is moot.
- Shadow update at each rising clk edge:
  - If mem_hold_i: all shadow state and counter keep their values.
  - Else if flush or bubble: EX <= {0,0,0,0}; MEM <= EX; WB <= MEM.
  - Else: EX <= {id_valid_i, id_rd_i, id_reg_we_i, id_is_load_i}; MEM <= EX fields (ld dropped); WB <= MEM.
- Latency:
  - A load in EX creates exactly one bubble cycle for a dependent ID instruction.
  - The next cycle the load is in MEM and the dependent instruction receives select 10.
- Counter: increments by 1 on each clock edge where hz_bubble_o = 1. Saturates at all-ones (no wrap). Held during freeze.
- Simultaneous events:
  - Branch taken during a load-use hazard: flush only, no bubble, no count.
  - Hold asserted mid-stall: stall_o stays 1, bubble_o drops to 0, and state freezes so the hazard re-evaluates after hold releases.

Test Plan:
- Back-to-back dependency, `add x5` then `sub` reading x5 as rs1 → fwd1_sel = 01, no stall. Next cycle, if the ID instruction also reads x5, fwd1_sel = 10.
- Load-use, `lw x7` then `add` reading x7 as rs2 → stall = bubble = 1 for one cycle; next cycle fwd2_sel = 10, stall = 0; counter = 1.
- x0 and RE gating:
  - Writer with rd = 0 followed by a reader of x0 → select 00, no stall.
  - Matching rs2 with reg2_RE = 0 → fwd2_sel = 00.
- Priority and events:
  - EX, MEM and WB all writing x3, ID reads x3 → select 01.
  - Load-use together with branch_taken → flush = 1, bubble = 0, counter unchanged.
- Hold and reset:
  - Assert mem_hold_i for 3 cycles during load-use → freeze = stall = 1, bubble = 0, shadow unchanged; on release, bubble = 1 for one cycle.
  - Assert rst mid-stream → all selects 00, counter 0 immediately.
- Counter saturation: with CNT_W = 4, force 17 bubbles → count = 15 and stays at 15.
